// File: rtl/vector_addsub_pipe.sv
// Two-stage lane-wise signed add/subtract with per-lane overflow, optional saturation,
// valid/ready handshake on both sides and a saturating overflow event counter.
module vector_addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int LANES    = 3,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic [LANES*WIDTH-1:0] op1,
  input  logic [LANES*WIDTH-1:0] op2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       overflow,
  output logic                   overflow_any,
  output logic [CNT_W-1:0]       ovf_count,
  input  logic                   ovf_clear
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The fixed-point format only matters to users; reject nonsensical layouts early.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must lie in [0, WIDTH)");
  end

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_cin_q, s1_cin_d;
  logic [LANES*WIDTH-1:0] s1_a_q, s1_a_d;
  logic [LANES*WIDTH-1:0] s1_b_q, s1_b_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] result_q, result_d;
  logic [LANES-1:0]       overflow_q, overflow_d;
  logic [CNT_W-1:0]       ovf_count_q, ovf_count_d;
  logic                   adv_out_s;
  logic [LANES*WIDTH-1:0] lane_res_s;
  logic [LANES-1:0]       lane_ovf_s;
  logic [LANES-1:0][WIDTH:0] sum_s;

  assign adv_out_s = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || adv_out_s;

  // Per-lane WIDTH+1-bit sum; the carry-in completes the two's complement of op2.
  always_comb begin
    lane_res_s = '0;
    lane_ovf_s = '0;
    sum_s      = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s[i] = {s1_a_q[i*WIDTH+WIDTH-1], s1_a_q[i*WIDTH +: WIDTH]}
               + {s1_b_q[i*WIDTH+WIDTH-1], s1_b_q[i*WIDTH +: WIDTH]}
               + {{WIDTH{1'b0}}, s1_cin_q};
      lane_ovf_s[i] = sum_s[i][WIDTH] ^ sum_s[i][WIDTH-1];
      if (lane_ovf_s[i] && (SATURATE != 0)) begin
        lane_res_s[i*WIDTH +: WIDTH] = sum_s[i][WIDTH] ? MIN_NEG : MAX_POS;
      end else begin
        lane_res_s[i*WIDTH +: WIDTH] = sum_s[i][WIDTH-1:0];
      end
    end
  end

  // Stage advance: S1 refills whenever it is free, S2 whenever the output moves.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cin_d    = s1_cin_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cin_d = sub;
        s1_a_d   = op1;
        s1_b_d   = sub ? ~op2 : op2;
      end else begin
        s1_cin_d = s1_cin_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (adv_out_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = lane_res_s;
        overflow_d = lane_ovf_s;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Clear takes priority, then a counted transfer adds one unless already at max.
  always_comb begin
    ovf_count_d = ovf_clear ? '0 : ovf_count_q;
    if (out_valid_q && out_ready && (|overflow_q) && (ovf_count_d != CNT_MAX)) begin
      ovf_count_d = ovf_count_d + CNT_ONE;
    end else begin
      ovf_count_d = ovf_count_d;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= '0;
      ovf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cin_q    <= s1_cin_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign overflow_any = |overflow_q;
  assign ovf_count    = ovf_count_q;

endmodule
